// File: rtl/rv_pkg.sv
// Shared definitions for the decode/execute slice.
//   XLEN       datapath width
//   RA_W       register address width
//   CTRL_W     width of the opaque decoded-control bundle
//   fwd_sel_e  operand source chosen by the forwarding mux
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RA_W   = 5;
    localparam int unsigned CTRL_W = 16;

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } fwd_sel_e;

endpackage

// File: rtl/operand_forward_mux.sv
// Priority operand select for one source register.
// Ports:
//   idx                      source register index
//   rf_data                  register_file read data for idx
//   ex_valid/ex_is_load/ex_rd/ex_result   instruction in EX
//   mem_valid/mem_rd/mem_result           instruction in MEM
//   wb_valid/wb_rd/wb_data                regfile write port this cycle
//   val                      selected operand value
module operand_forward_mux #(
    parameter int unsigned XLEN = rv_pkg::XLEN,
    parameter int unsigned RA_W = rv_pkg::RA_W
) (
    input  logic [RA_W-1:0] idx,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_valid,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] val
);
    import rv_pkg::*;

    fwd_sel_e sel;

    // Checking idx==0 first also keeps any producer with rd==0 from forwarding.
    // A load in EX has no result yet; the hazard unit stalls on it instead.
    always_comb begin
        sel = FWD_RF;
        if (idx == '0)
            sel = FWD_ZERO;
        else if (ex_valid && !ex_is_load && ex_rd == idx)
            sel = FWD_EX;
        else if (mem_valid && mem_rd == idx)
            sel = FWD_MEM;
        else if (wb_valid && wb_rd == idx)
            sel = FWD_WB;   // regfile write lands at the edge, read is still old
    end

    always_comb begin
        val = rf_data;
        case (sel)
            FWD_ZERO: val = '0;
            FWD_EX:   val = ex_result;
            FWD_MEM:  val = mem_result;
            FWD_WB:   val = wb_data;
            default:  val = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode->execute stage: drives the regfile read selects, forwards results
// from EX/MEM/WB, stalls on load-use and holds one instruction in the ID/EX
// register under a valid/ready handshake with flush.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_*                     decoded instruction and its handshake
//   rf_sel_rs1/2, rf_data_rs1/2  register_file read port
//   ex_*, mem_*, wb_*        forwarding sources from later stages
//   flush                    kill held and incoming instruction
//   out_*                    ID/EX slot and its handshake
//   stall_count              saturating count of load-use stall cycles
module operand_fetch_stage #(
    parameter int unsigned XLEN   = rv_pkg::XLEN,
    parameter int unsigned RA_W   = rv_pkg::RA_W,
    parameter int unsigned CTRL_W = rv_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [RA_W-1:0]   in_rs1,
    input  logic [RA_W-1:0]   in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_is_load,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [RA_W-1:0]   rf_sel_rs1,
    output logic [RA_W-1:0]   rf_sel_rs2,
    input  logic [XLEN-1:0]   rf_data_rs1,
    input  logic [XLEN-1:0]   rf_data_rs2,
    input  logic              ex_valid,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_is_load,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              mem_valid,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_valid,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [RA_W-1:0]   out_rd,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       stall_count
);
    import rv_pkg::*;

    logic            load_use;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign rf_sel_rs1 = in_rs1;
    assign rf_sel_rs2 = in_rs2;

    operand_forward_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .idx        (in_rs1),
        .rf_data    (rf_data_rs1),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .val        (rs1_val)
    );

    operand_forward_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .idx        (in_rs2),
        .rf_data    (rf_data_rs2),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .val        (rs2_val)
    );

    // A load in EX cannot forward; hold the consumer one cycle until the
    // data reaches MEM.
    assign load_use = in_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                      ((in_use_rs1 && in_rs1 == ex_rd) ||
                       (in_use_rs2 && in_rs2 == ex_rd));

    assign in_ready = !rst && !flush && !load_use && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Flush wins over accept; a bubble clears only valid, data keeps its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_is_load <= 1'b0;
            out_ctrl    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_imm     <= in_imm;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_rd      <= in_rd;
            out_is_load <= in_is_load;
            out_ctrl    <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (load_use && !flush && stall_count != '1)
            stall_count <= stall_count + 32'd1;
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_use_rs1;
    logic        in_use_rs2;
    logic [4:0]  in_rd;
    logic        in_is_load;
    logic [31:0] in_imm;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_sel_rs1;
    logic [4:0]  rf_sel_rs2;
    logic [31:0] rf_data_rs1;
    logic [31:0] rf_data_rs2;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic [31:0] ex_result;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_is_load;
    logic [15:0] out_ctrl;
    logic [31:0] stall_count;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_is_load(in_is_load), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_sel_rs1(rf_sel_rs1), .rf_sel_rs2(rf_sel_rs2),
        .rf_data_rs1(rf_data_rs1), .rf_data_rs2(rf_data_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_is_load(out_is_load), .out_ctrl(out_ctrl),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state of the ID/EX slot.
    logic        m_valid;
    logic [31:0] m_pc, m_imm, m_rs1v, m_rs2v;
    logic [4:0]  m_rd;
    logic        m_load;
    logic [15:0] m_ctrl;
    longint unsigned m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value the architecture expects for source idx: newest in-flight producer wins.
    function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'd0;
        if (ex_valid && !ex_is_load && ex_rd == idx) return ex_result;
        if (mem_valid && mem_rd == idx) return mem_result;
        if (wb_valid && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    // One clock: checks combinational outputs, advances the model, checks registered outputs.
    task automatic step();
        logic lu, rdy, acc;
        logic [31:0] e1, e2;
        #1;
        lu = in_valid && ex_valid && ex_is_load && ex_rd != 0 &&
             ((in_use_rs1 && in_rs1 == ex_rd) || (in_use_rs2 && in_rs2 == ex_rd));
        rdy = !rst && !flush && !lu && (!m_valid || out_ready);
        acc = in_valid && rdy;
        e1 = ref_operand(in_rs1, rf_data_rs1);
        e2 = ref_operand(in_rs2, rf_data_rs2);
        chk("in_ready", in_ready, rdy);
        chk("rf_sel_rs1", rf_sel_rs1, in_rs1);
        chk("rf_sel_rs2", rf_sel_rs2, in_rs2);
        if (rst) begin
            m_valid = 0; m_pc = 0; m_imm = 0; m_rs1v = 0; m_rs2v = 0;
            m_rd = 0; m_load = 0; m_ctrl = 0; m_stall = 0;
        end else begin
            if (lu && !flush && m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
            if (flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_rs1v = e1; m_rs2v = e2;
                m_rd = in_rd; m_load = in_is_load; m_ctrl = in_ctrl;
            end else if (out_ready) m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_pc", out_pc, m_pc);
        chk("out_imm", out_imm, m_imm);
        chk("out_rs1_val", out_rs1_val, m_rs1v);
        chk("out_rs2_val", out_rs2_val, m_rs2v);
        chk("out_rd", out_rd, m_rd);
        chk("out_is_load", out_is_load, m_load);
        chk("out_ctrl", out_ctrl, m_ctrl);
        chk("stall_count", stall_count, m_stall[31:0]);
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
        in_rd = 0; in_is_load = 0; in_imm = 0; in_ctrl = 0;
        rf_data_rs1 = 0; rf_data_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_result = 0;
        mem_valid = 0; mem_rd = 0; mem_result = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        use1, use2;
        logic [31:0] rf1, rf2;
        logic        exv;  logic [4:0] exrd;  logic exld; logic [31:0] exres;
        logic        memv; logic [4:0] memrd; logic [31:0] memres;
        logic        wbv;  logic [4:0] wbrd;  logic [31:0] wbd;
        logic [31:0] exp1, exp2;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{5'd3, 5'd0, 1'b1, 1'b1, 32'h5,  32'h99, 1'b0, 5'd0, 1'b0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  32'h5,  32'h0};
        vecs[1] = '{5'd4, 5'd4, 1'b1, 1'b1, 32'h44, 32'h44, 1'b1, 5'd4, 1'b0, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b1, 5'd4, 32'hCC, 32'hAA, 32'hAA};
        vecs[2] = '{5'd4, 5'd4, 1'b1, 1'b1, 32'h44, 32'h44, 1'b0, 5'd4, 1'b0, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b1, 5'd4, 32'hCC, 32'hBB, 32'hBB};
        vecs[3] = '{5'd4, 5'd4, 1'b1, 1'b1, 32'h44, 32'h44, 1'b0, 5'd4, 1'b0, 32'hAA, 1'b0, 5'd4, 32'hBB, 1'b1, 5'd4, 32'hCC, 32'hCC, 32'hCC};
        vecs[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 32'h12, 32'h34, 1'b1, 5'd0, 1'b0, 32'h11, 1'b1, 5'd0, 32'h22, 1'b1, 5'd0, 32'hFF, 32'h0,  32'h0};
        vecs[5] = '{5'd4, 5'd5, 1'b0, 1'b0, 32'h44, 32'h55, 1'b1, 5'd4, 1'b1, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b0, 5'd0, 32'h0,  32'hBB, 32'h55};
        vecs[6] = '{5'd3, 5'd2, 1'b1, 1'b1, 32'h33, 32'h22, 1'b1, 5'd2, 1'b0, 32'hEE, 1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h77, 32'h77, 32'hEE};
        vecs[7] = '{5'd6, 5'd1, 1'b1, 1'b1, 32'h60, 32'h10, 1'b0, 5'd0, 1'b0, 32'h0,  1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h77, 32'h66, 32'h10};

        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;

        // Reset then idle.
        in_valid = 0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        step();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_stall_count", stall_count, 0);

        // Forwarding table.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; out_ready = 1;
            in_pc = 32'h100 + 32'(i) * 4; in_imm = 32'(i); in_rd = 5'(i + 1); in_ctrl = 16'(i * 3);
            in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
            in_use_rs1 = vecs[i].use1; in_use_rs2 = vecs[i].use2;
            rf_data_rs1 = vecs[i].rf1; rf_data_rs2 = vecs[i].rf2;
            ex_valid = vecs[i].exv; ex_rd = vecs[i].exrd; ex_is_load = vecs[i].exld; ex_result = vecs[i].exres;
            mem_valid = vecs[i].memv; mem_rd = vecs[i].memrd; mem_result = vecs[i].memres;
            wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbd;
            step();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_rs1", i), out_rs1_val, vecs[i].exp1);
            chk($sformatf("vec%0d_rs2", i), out_rs2_val, vecs[i].exp2);
        end

        // Load-use: one bubble, then the load's data arrives from MEM.
        clear_inputs();
        rst = 1; step(); rst = 0;
        in_valid = 1; in_pc = 32'h400; in_rs2 = 7; in_use_rs2 = 1; in_rd = 9;
        ex_valid = 1; ex_is_load = 1; ex_rd = 7; ex_result = 32'hDEAD;
        #1;
        chk("lu_in_ready", in_ready, 0);
        step();
        chk("lu_bubble", out_valid, 0);
        chk("lu_stall_count", stall_count, 1);
        ex_valid = 0; ex_is_load = 0;
        mem_valid = 1; mem_rd = 7; mem_result = 32'h1234;
        step();
        chk("lu_resume_valid", out_valid, 1);
        chk("lu_mem_fwd", out_rs2_val, 32'h1234);
        chk("lu_stall_hold", stall_count, 1);

        // Backpressure: held slot stays stable, then the next instruction is taken.
        mem_valid = 0; out_ready = 0;
        in_pc = 32'h500; in_rs2 = 3; rf_data_rs2 = 32'h77;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            step();
            chk("bp_pc_held", out_pc, 32'h400);
            chk("bp_rs2_held", out_rs2_val, 32'h1234);
            chk("bp_valid_held", out_valid, 1);
        end
        out_ready = 1;
        step();
        chk("bp_release_pc", out_pc, 32'h500);
        chk("bp_release_rs2", out_rs2_val, 32'h77);

        // Flush concurrent with an accept.
        flush = 1; in_pc = 32'h600;
        step();
        chk("flush_valid", out_valid, 0);
        chk("flush_pc_kept", out_pc, 32'h500);
        flush = 0;
        step();
        chk("post_flush_pc", out_pc, 32'h600);

        // Reset with an instruction held.
        out_ready = 0; in_valid = 1;
        rst = 1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        rst = 0;

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rst        = ($urandom_range(0, 99) < 2);
            flush      = ($urandom_range(0, 99) < 5);
            in_valid   = ($urandom_range(0, 99) < 80);
            out_ready  = ($urandom_range(0, 99) < 70);
            in_pc      = $urandom; in_imm = $urandom; in_ctrl = 16'($urandom);
            in_rs1     = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
            in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom);
            in_rd      = 5'($urandom_range(0, 7)); in_is_load = 1'($urandom);
            rf_data_rs1 = $urandom; rf_data_rs2 = $urandom;
            ex_valid   = 1'($urandom); ex_rd = 5'($urandom_range(0, 7));
            ex_is_load = ($urandom_range(0, 99) < 30); ex_result = $urandom;
            mem_valid  = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
            wb_valid   = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
